booth_mult_seq: RTL and testbench

Sequential signed multiplier controller. It computes a WIDTH×WIDTH two's-complement product with radix-2 Booth recoding. It sequences a single shared signed add/subtract unit over WIDTH iterations, one per clock. It sits beside the signed adder/subtractor in the arithmetic library as the first multi-cycle consumer of that unit.

---
 rtl/booth_mult_seq_pkg.sv | 19 +
 rtl/adder_subtractor_signed_dut.sv | 22 ++
 rtl/booth_mult_seq.sv | 106 ++++++++++
 tb/tb_booth_mult_seq.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/booth_mult_seq_pkg.sv
// Shared definitions for the radix-2 Booth sequential multiplier:
// controller state encoding, Booth recode values and counter sizing.
package booth_mult_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Booth recode of {Q[0], q1}; 00 and 11 mean "shift only"
    localparam logic [1:0] BOOTH_ADD = 2'b01;
    localparam logic [1:0] BOOTH_SUB = 2'b10;

    function automatic int count_width(input int width);
        return (width > 2) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/adder_subtractor_signed_dut.sv
// Signed two's-complement adder/subtractor: sum = x + y, or x - y when add_n = 1
// (inverted y plus carry-in), with carry-out and signed overflow flags.
module adder_subtractor_signed_dut #(
    parameter int WIDTH = 5
) (
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             add_n,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             overflow
);

    logic [WIDTH-1:0] y_eff;

    assign y_eff = y ^ {WIDTH{add_n}};
    assign {carry_out, sum} = {1'b0, x} + {1'b0, y_eff} + {{WIDTH{1'b0}}, add_n};

    // Overflow when both effective operands share a sign the result does not
    assign overflow = (x[WIDTH-1] == y_eff[WIDTH-1]) && (sum[WIDTH-1] != x[WIDTH-1]);

endmodule

// File: rtl/booth_mult_seq.sv
// Sequential WIDTH x WIDTH signed multiplier: one radix-2 Booth step per clock
// through a shared WIDTH+1 bit add/sub unit, with a one-cycle done pulse.
module booth_mult_seq
    import booth_mult_seq_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int CW = count_width(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state;
    logic [WIDTH:0]   m;
    logic [WIDTH:0]   acc;
    logic [WIDTH-1:0] q;
    logic             q1;
    logic [CW-1:0]    count;

    logic [1:0]       code;
    logic             add_n;
    logic [WIDTH:0]   sum;
    logic             carry;
    logic             ovf;
    logic [WIDTH:0]   step;
    logic [WIDTH:0]   acc_next;
    logic [WIDTH-1:0] q_next;
    logic             unused_carry;

    assign code  = {q[0], q1};
    assign add_n = (code == BOOTH_SUB);

    adder_subtractor_signed_dut #(
        .WIDTH (WIDTH + 1)
    ) u_addsub (
        .x         (acc),
        .y         (m),
        .add_n     (add_n),
        .sum       (sum),
        .carry_out (carry),
        .overflow  (ovf)
    );

    assign unused_carry = carry;

    assign step     = (code == BOOTH_ADD || code == BOOTH_SUB) ? sum : acc;
    assign acc_next = {step[WIDTH], step[WIDTH:1]};
    assign q_next   = {step[0], q[WIDTH-1:1]};

    // DONE behaves like IDLE for start acceptance, giving back-to-back operation
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            product <= '0;
            m       <= '0;
            acc     <= '0;
            q       <= '0;
            q1      <= 1'b0;
            count   <= '0;
        end else begin
            case (state)
                ST_RUN: begin
                    acc   <= acc_next;
                    q     <= q_next;
                    q1    <= q[0];
                    count <= count + CW'(1);
                    if (count == LAST) begin
                        product <= {acc_next[WIDTH-1:0], q_next};
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        state   <= ST_DONE;
                    end
                end
                default: begin
                    done <= 1'b0;
                    if (start) begin
                        m     <= {a[WIDTH-1], a};
                        acc   <= '0;
                        q     <= b;
                        q1    <= 1'b0;
                        count <= '0;
                        busy  <= 1'b1;
                        state <= ST_RUN;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    // The WIDTH+1 bit datapath makes every Booth step overflow-free
    no_step_overflow: assert property (@(posedge clk) disable iff (rst)
        (state == ST_RUN) |-> !ovf);

endmodule

// File: tb/tb_booth_mult_seq.sv
// Self-checking bench for booth_mult_seq: directed and random products against
// an integer-multiply reference, plus back-to-back, ignored-start and reset cases.
module tb_booth_mult_seq;

    localparam int W = 4;

    logic           clk;
    logic           rst;
    logic           start;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           busy;
    logic           done;
    logic [2*W-1:0] product;

    int tests_run = 0;
    int failures  = 0;

    int             dir_x [5] = '{3, -8, -8, 7, 0};
    int             dir_y [5] = '{5, -8, 7, -1, -5};
    logic [2*W-1:0] dir_p [5] = '{8'h0F, 8'h40, 8'hC8, 8'hF9, 8'h00};

    booth_mult_seq #(
        .WIDTH (W)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [2*W-1:0] ref_mult(input int x, input int y);
        int p;
        p = x * y;
        return p[2*W-1:0];
    endfunction

    // Starts one multiply from an idle/done phase and waits for the done pulse.
    task automatic do_multiply(input int x, input int y,
                               output logic [2*W-1:0] prod, output int edges,
                               output int busy_cycles, output bit seen);
        start = 1'b1;
        a = W'(x);
        b = W'(y);
        @(posedge clk); #1;
        start = 1'b0;
        edges = 1;
        busy_cycles = 0;
        seen = 1'b0;
        prod = '0;
        while (edges <= 20) begin
            if (busy) busy_cycles++;
            if (done) begin
                seen = 1'b1;
                prod = product;
                break;
            end
            @(posedge clk); #1;
            edges++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b0;
        a = '0;
        b = '0;
        repeat (2) @(posedge clk);
        #1;
        tests_run++;
        if (busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_busy: got %b expected 0", busy);
        end
        tests_run++;
        if (done !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_done: got %b expected 0", done);
        end
        tests_run++;
        if (product !== '0) begin
            failures++;
            $display("[TB] FAIL reset_product: got %h expected 00", product);
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        logic [2*W-1:0] prod;
        int edges, bcycles;
        bit seen;
        for (int i = 0; i < 5; i++) begin
            do_multiply(dir_x[i], dir_y[i], prod, edges, bcycles, seen);
            tests_run++;
            if (seen !== 1'b1) begin
                failures++;
                $display("[TB] FAIL directed_timeout[%0d]: no done within %0d edges", i, edges);
            end
            tests_run++;
            if (prod !== dir_p[i]) begin
                failures++;
                $display("[TB] FAIL directed_product %0d*%0d: got %h expected %h",
                         dir_x[i], dir_y[i], prod, dir_p[i]);
            end
            tests_run++;
            if (edges !== W + 1) begin
                failures++;
                $display("[TB] FAIL directed_latency[%0d]: got %0d edges expected %0d", i, edges, W + 1);
            end
            tests_run++;
            if (bcycles !== W) begin
                failures++;
                $display("[TB] FAIL directed_busy_cycles[%0d]: got %0d expected %0d", i, bcycles, W);
            end
            @(posedge clk); #1;
            tests_run++;
            if (done !== 1'b0 || product !== dir_p[i]) begin
                failures++;
                $display("[TB] FAIL directed_pulse_hold[%0d]: done=%b product=%h expected done=0 product=%h",
                         i, done, product, dir_p[i]);
            end
        end
    endtask

    task automatic test_random();
        logic [2*W-1:0] prod;
        logic [2*W-1:0] expected;
        int edges, bcycles, x, y;
        bit seen;
        for (int i = 0; i < 24; i++) begin
            x = int'($urandom_range(15)) - 8;
            y = int'($urandom_range(15)) - 8;
            expected = ref_mult(x, y);
            do_multiply(x, y, prod, edges, bcycles, seen);
            tests_run++;
            if (seen !== 1'b1 || prod !== expected || edges !== W + 1) begin
                failures++;
                $display("[TB] FAIL random_product %0d*%0d: got %h (done=%b, %0d edges) expected %h in %0d edges",
                         x, y, prod, seen, edges, expected, W + 1);
            end
            if ($urandom_range(1) == 1) begin
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic test_back_to_back();
        int             done_edges [$];
        logic [2*W-1:0] prods [$];
        logic [2*W-1:0] exp0, exp1;
        exp0 = ref_mult(2, 3);
        exp1 = ref_mult(-2, 3);
        start = 1'b1;
        a = W'(2);
        b = W'(3);
        @(posedge clk); #1;
        a = W'(-2);
        b = W'(3);
        for (int k = 1; k < 16; k++) begin
            @(posedge clk); #1;
            if (k == 5) start = 1'b0;
            if (done) begin
                done_edges.push_back(k);
                prods.push_back(product);
            end
        end
        tests_run++;
        if (done_edges.size() !== 2) begin
            failures++;
            $display("[TB] FAIL b2b_pulse_count: got %0d expected 2", done_edges.size());
        end else begin
            tests_run++;
            if (done_edges[1] - done_edges[0] !== W + 1) begin
                failures++;
                $display("[TB] FAIL b2b_spacing: got %0d cycles expected %0d",
                         done_edges[1] - done_edges[0], W + 1);
            end
            tests_run++;
            if (prods[0] !== exp0 || prods[1] !== exp1) begin
                failures++;
                $display("[TB] FAIL b2b_products: got %h,%h expected %h,%h", prods[0], prods[1], exp0, exp1);
            end
        end
    endtask

    task automatic test_start_while_busy();
        int             pulses;
        int             done_k;
        logic [2*W-1:0] got;
        logic [2*W-1:0] expected;
        expected = ref_mult(5, -3);
        pulses = 0;
        done_k = -1;
        got = '0;
        start = 1'b1;
        a = W'(5);
        b = W'(-3);
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 1; k < 16; k++) begin
            @(posedge clk); #1;
            if (k == 2) begin
                start = 1'b1;
                a = W'(7);
                b = W'(7);
            end
            if (k == 3) start = 1'b0;
            if (done) begin
                pulses++;
                done_k = k;
                got = product;
            end
        end
        tests_run++;
        if (pulses !== 1 || done_k !== W) begin
            failures++;
            $display("[TB] FAIL busy_start_pulses: got %0d pulses (last at edge %0d) expected 1 at edge %0d",
                     pulses, done_k, W);
        end
        tests_run++;
        if (got !== expected) begin
            failures++;
            $display("[TB] FAIL busy_start_product: got %h expected %h", got, expected);
        end
        tests_run++;
        if (busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL busy_start_idle: busy got %b expected 0", busy);
        end
        a = '0;
        b = '0;
    endtask

    task automatic test_reset_mid_run();
        logic [2*W-1:0] prod;
        logic [2*W-1:0] expected;
        int edges, bcycles;
        bit seen;
        expected = ref_mult(-7, 6);
        start = 1'b1;
        a = W'(-7);
        b = W'(6);
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        tests_run++;
        if (busy !== 1'b0 || done !== 1'b0 || product !== '0) begin
            failures++;
            $display("[TB] FAIL midrun_reset: busy=%b done=%b product=%h expected 0 0 00", busy, done, product);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        do_multiply(-7, 6, prod, edges, bcycles, seen);
        tests_run++;
        if (seen !== 1'b1 || prod !== expected || edges !== W + 1) begin
            failures++;
            $display("[TB] FAIL midrun_restart: got %h (done=%b, %0d edges) expected %h in %0d edges",
                     prod, seen, edges, expected, W + 1);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_start_while_busy();
        test_reset_mid_run();
        $display("[TB] %0d tests run, %0d failed", tests_run, failures);
        $finish;
    end

endmodule
